// File: rtl/int_mult_arbiter.sv
// Round-robin arbiter that shares one combinational int_mult datapath between NB_CORES cores,
// with a fixed-latency result pipeline and a saturating contention counter.
module int_mult_arbiter #(
  parameter int unsigned NB_CORES    = 4,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ID_WIDTH    = $clog2(NB_CORES)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NB_CORES-1:0]           req_i,
  output logic [NB_CORES-1:0]           gnt_o,
  input  logic [NB_CORES-1:0][2:0]      operator_i,
  input  logic [NB_CORES-1:0][31:0]     op_a_i,
  input  logic [NB_CORES-1:0][31:0]     op_b_i,
  input  logic [NB_CORES-1:0][31:0]     op_c_i,
  input  logic [NB_CORES-1:0][4:0]      imm_i,
  input  logic [NB_CORES-1:0]           short_subword_i,
  input  logic [NB_CORES-1:0][1:0]      short_signed_i,
  output logic [2:0]                    mult_operator_o,
  output logic [31:0]                   mult_op_a_o,
  output logic [31:0]                   mult_op_b_o,
  output logic [31:0]                   mult_op_c_o,
  output logic [4:0]                    mult_imm_o,
  output logic                          mult_short_subword_o,
  output logic [1:0]                    mult_short_signed_o,
  input  logic [31:0]                   mult_result_i,
  output logic [NB_CORES-1:0]           rvalid_o,
  output logic [31:0]                   result_o,
  input  logic                          clear_cnt_i,
  output logic [31:0]                   contention_cnt_o
);

  logic [ID_WIDTH-1:0]                  rr_q;
  logic [ID_WIDTH-1:0]                  winner;
  logic [ID_WIDTH-1:0]                  idx;
  logic                                 gnt_valid;
  logic [PIPE_STAGES-1:0]               vld_q;
  logic [PIPE_STAGES-1:0][ID_WIDTH-1:0] id_q;
  logic [31:0]                          cnt_q;
  logic                                 contended;

  // Scan from the priority pointer, wrapping modulo NB_CORES.
  always_comb begin
    gnt_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      idx = ID_WIDTH'((32'(rr_q) + i) % NB_CORES);
      if (!gnt_valid && req_i[idx]) begin
        gnt_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  assign gnt_o = gnt_valid ? (NB_CORES'(1) << winner) : '0;

  // Issue stage: operand registers hold when idle so the multiplier does not toggle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q                 <= '0;
      vld_q[0]             <= 1'b0;
      id_q[0]              <= '0;
      mult_operator_o      <= '0;
      mult_op_a_o          <= '0;
      mult_op_b_o          <= '0;
      mult_op_c_o          <= '0;
      mult_imm_o           <= '0;
      mult_short_subword_o <= 1'b0;
      mult_short_signed_o  <= '0;
    end else begin
      vld_q[0] <= gnt_valid;
      if (gnt_valid) begin
        rr_q                 <= (winner == ID_WIDTH'(NB_CORES - 1)) ? '0 : winner + 1'b1;
        id_q[0]              <= winner;
        mult_operator_o      <= operator_i[winner];
        mult_op_a_o          <= op_a_i[winner];
        mult_op_b_o          <= op_b_i[winner];
        mult_op_c_o          <= op_c_i[winner];
        mult_imm_o           <= imm_i[winner];
        mult_short_subword_o <= short_subword_i[winner];
        mult_short_signed_o  <= short_signed_i[winner];
      end
    end
  end

  for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_ctrl_pipe
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
      end else begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  if (PIPE_STAGES > 1) begin : g_res_pipe
    // res_q[j] is fed by the stage whose valid is vld_q[j]; loads only on valid.
    logic [PIPE_STAGES-2:0][31:0] res_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        res_q[0] <= '0;
      end else if (vld_q[0]) begin
        res_q[0] <= mult_result_i;
      end
    end

    for (genvar s = 1; s < PIPE_STAGES - 1; s++) begin : g_res_stage
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          res_q[s] <= '0;
        end else if (vld_q[s]) begin
          res_q[s] <= res_q[s-1];
        end
      end
    end

    assign result_o = res_q[PIPE_STAGES-2];
  end else begin : g_res_comb
    assign result_o = mult_result_i;
  end

  assign rvalid_o = vld_q[PIPE_STAGES-1] ? (NB_CORES'(1) << id_q[PIPE_STAGES-1]) : '0;

  assign contended = ($countones(req_i) >= 2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_cnt_i) begin
      cnt_q <= '0;
    end else if (contended && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_int_mult_arbiter.sv
// Scoreboard bench for int_mult_arbiter: directed requests, a monitor pops expected results.
module tb_int_mult_arbiter;
  localparam int unsigned P = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [3:0]        req_i;
  logic [3:0]        gnt_o;
  logic [3:0][2:0]   operator_i;
  logic [3:0][31:0]  op_a_i, op_b_i, op_c_i;
  logic [3:0][4:0]   imm_i;
  logic [3:0]        short_subword_i;
  logic [3:0][1:0]   short_signed_i;
  logic [2:0]        mult_operator_o;
  logic [31:0]       mult_op_a_o, mult_op_b_o, mult_op_c_o;
  logic [4:0]        mult_imm_o;
  logic              mult_short_subword_o;
  logic [1:0]        mult_short_signed_o;
  logic [31:0]       mult_result_i;
  logic [3:0]        rvalid_o;
  logic [31:0]       result_o;
  logic              clear_cnt_i;
  logic [31:0]       contention_cnt_o;

  int_mult_arbiter #(.NB_CORES(4), .PIPE_STAGES(P)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_i                (req_i),
    .gnt_o                (gnt_o),
    .operator_i           (operator_i),
    .op_a_i               (op_a_i),
    .op_b_i               (op_b_i),
    .op_c_i               (op_c_i),
    .imm_i                (imm_i),
    .short_subword_i      (short_subword_i),
    .short_signed_i       (short_signed_i),
    .mult_operator_o      (mult_operator_o),
    .mult_op_a_o          (mult_op_a_o),
    .mult_op_b_o          (mult_op_b_o),
    .mult_op_c_o          (mult_op_c_o),
    .mult_imm_o           (mult_imm_o),
    .mult_short_subword_o (mult_short_subword_o),
    .mult_short_signed_o  (mult_short_signed_o),
    .mult_result_i        (mult_result_i),
    .rvalid_o             (rvalid_o),
    .result_o             (result_o),
    .clear_cnt_i          (clear_cnt_i),
    .contention_cnt_o     (contention_cnt_o)
  );

  // Stand-in for int_mult: operator 0 is MAC32, anything else a plain multiply.
  assign mult_result_i = (mult_operator_o == 3'd0) ? mult_op_a_o * mult_op_b_o + mult_op_c_o
                                                   : mult_op_a_o * mult_op_b_o;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // Per-core MAC32 results: 2*3+1, 3*5+7, 4*6+0, 10*10+5.
  logic [31:0] exp_tab [4] = '{32'd7, 32'd22, 32'd24, 32'd105};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; leaves at the next negedge.
  task automatic drive(input logic [3:0] req, input logic [3:0] exp_gnt,
                       input logic [31:0] exp_res, input bit push = 1'b1);
    exp_t e;
    req_i = req;
    #1;
    check("gnt", 32'(gnt_o), 32'(exp_gnt));
    if (push && exp_gnt != 4'd0) begin
      e.mask = exp_gnt;
      e.res  = exp_res;
      e.due  = cyc + int'(P);
      sb.push_back(e);
    end
    @(negedge clk_i);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("rvalid_missing", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (rvalid_o != 4'd0) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 32'(rvalid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid", 32'(rvalid_o), 32'(e.mask));
          check("result", result_o, e.res);
          check("latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_ni      = 1'b0;
    req_i       = '0;
    clear_cnt_i = 1'b0;
    operator_i  = '0;
    imm_i       = '0;
    short_subword_i = '0;
    short_signed_i  = '0;
    op_a_i[0] = 32'd2;  op_b_i[0] = 32'd3;  op_c_i[0] = 32'd1;
    op_a_i[1] = 32'd3;  op_b_i[1] = 32'd5;  op_c_i[1] = 32'd7;
    op_a_i[2] = 32'd4;  op_b_i[2] = 32'd6;  op_c_i[2] = 32'd0;
    op_a_i[3] = 32'd10; op_b_i[3] = 32'd10; op_c_i[3] = 32'd5;

    repeat (3) @(negedge clk_i);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_op_a", mult_op_a_o, 32'd0);
    check("rst_op_c", mult_op_c_o, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_cnt", contention_cnt_o, 32'd0);
    rst_ni = 1'b1;
    while (cyc < 10) @(negedge clk_i);

    // Single core, then idle stability.
    drive(4'b0010, 4'b0010, 32'd22);
    repeat (5) drive(4'b0000, 4'b0000, 32'd0);
    check("idle_op_a", mult_op_a_o, 32'd3);
    check("idle_rr", 32'(dut.rr_q), 32'd2);
    check("idle_rvalid", 32'(rvalid_o), 32'd0);

    // Fairness from reset.
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) drive(4'hF, 4'(1 << k), exp_tab[k]);
    drive(4'b0000, 4'b0000, 32'd0);
    check("fair_cnt", contention_cnt_o, 32'd8);
    repeat (3) drive(4'b0000, 4'b0000, 32'd0);

    // Pointer wrap and skipping.
    drive(4'b0100, 4'b0100, 32'd24);
    check("wrap_rr3", 32'(dut.rr_q), 32'd3);
    drive(4'b1010, 4'b1000, 32'd105);
    drive(4'b0010, 4'b0010, 32'd22);
    check("wrap_rr2", 32'(dut.rr_q), 32'd2);
    check("wrap_cnt", contention_cnt_o, 32'd9);

    // Saturation, then clear with four requests active.
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    drive(4'hF, 4'b0100, 32'd24);
    drive(4'hF, 4'b1000, 32'd105);
    drive(4'hF, 4'b0001, 32'd7);
    check("sat_cnt", contention_cnt_o, 32'hFFFF_FFFF);
    clear_cnt_i = 1'b1;
    drive(4'hF, 4'b0010, 32'd22);
    clear_cnt_i = 1'b0;
    check("clear_cnt", contention_cnt_o, 32'd0);
    repeat (3) drive(4'b0000, 4'b0000, 32'd0);

    // Reset mid-flight: the in-flight op must never return.
    drive(4'b0001, 4'b0001, 32'd0, 1'b0);
    req_i  = '0;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
    check("mid_rst_op_a", mult_op_a_o, 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_cnt", contention_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(4'b1001, 4'b0001, 32'd7);
    repeat (P + 3) drive(4'b0000, 4'b0000, 32'd0);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
